sub_div_ctrl: RTL

Sequential restoring-division controller for the ALU that time-shares one 6-bit `subtractor` instance over six iterations to produce an unsigned quotient and remainder. It accepts a start pulse with operands, runs a three-state FSM (IDLE, RUN, DONE), and returns results with a one-cycle `done` pulse. It sits beside the add/sub datapath and is the ALU's divide path.

---
 rtl/sub_div_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sub_div_ctrl.sv
// ---------------------------------------------------------------------------
// sub_div_ctrl -- sequential restoring divider for the ALU divide path.
//
// One 6-bit subtractor is shared over six iterations to produce an unsigned
// quotient and remainder. A start pulse in IDLE/DONE latches the operands.
// RUN performs one shift/subtract step per cycle. DONE holds `done` high for
// exactly one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, honoured only in IDLE or DONE
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while iterating (RUN)
//   done         one-cycle completion pulse
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  set with done when divisor was zero
//
// Build option: define SUB_DIV_FAST_EN to finish in one cycle when
// dividend < divisor. In that case no iterations run.
// ---------------------------------------------------------------------------

// Borrow-style subtractor: cout=1 means no borrow (a >= b + cin).
module subtractor #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);
    logic [WIDTH:0] full;

    assign full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign diff = full[WIDTH-1:0];
    assign cout = ~full[WIDTH];
endmodule

module sub_div_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;       // partial remainder
    logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient in
    logic [WIDTH-1:0] d_q, d_d;       // latched divisor
    logic [2:0]       cnt_q, cnt_d;   // iteration counter
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // One iteration of restoring division.
    logic             msb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             accept;

    assign msb     = r_q[WIDTH-1];
    assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    subtractor #(.WIDTH(WIDTH)) u_sub (
        .a    (shifted),
        .b    (d_q),
        .cin  (1'b0),
        .diff (diff),
        .cout (no_borrow)
    );

    // With msb set the true 7-bit value {msb,shifted} is at least 64, which
    // exceeds any divisor. Because the remainder stays below 64, the 6-bit
    // wrapped difference is still exact.
    assign accept = msb | no_borrow;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = 3'd0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`ifdef SUB_DIV_FAST_EN
                    else if (dividend < divisor) begin
                        state_d = DONE;
                        quot_d  = '0;
                        rem_d   = dividend;
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                r_d   = accept ? diff : shifted;
                q_d   = {q_q[WIDTH-2:0], accept};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    // Publish the final step's results on the same edge
                    // that enters DONE.
                    state_d = DONE;
                    quot_d  = {q_q[WIDTH-2:0], accept};
                    rem_d   = accept ? diff : shifted;
                    dbz_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= 3'd0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
